// File: rtl/and_gate_checker.sv
// Response checker for a parameterised AND gate: compares each sampled DUT output
// against the golden reduction-AND, counts vectors/errors and captures the first failure.
module and_gate_checker #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             vec_valid,
  input  logic [WIDTH-1:0] vec_x,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] vec_cnt,
  output logic             fail_seen,
  output logic [WIDTH-1:0] first_fail_x,
  output logic [CNT_W-1:0] first_fail_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic             fail_q, fail_d;
  logic [WIDTH-1:0] ffx_q, ffx_d;
  logic [CNT_W-1:0] ffidx_q, ffidx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             expected_c;
  logic             mismatch_c;

  // Case-inequality so an X/Z on the DUT output is flagged as a failure.
  assign expected_c = &vec_x;
  assign mismatch_c = (dut_y !== expected_c);

  // Next-state and result update logic.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    err_d   = err_q;
    vec_d   = vec_q;
    fail_d  = fail_q;
    ffx_d   = ffx_q;
    ffidx_d = ffidx_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          err_d   = '0;
          vec_d   = '0;
          fail_d  = 1'b0;
          ffx_d   = '0;
          ffidx_d = '0;
          num_d   = num_vec;
          state_d = (num_vec != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (vec_valid) begin
          vec_d = vec_q + CNT_W'(1);
          if (mismatch_c) begin
            if (err_q != {CNT_W{1'b1}}) begin
              err_d = err_q + CNT_W'(1);
            end
            if (!fail_q) begin
              fail_d  = 1'b1;
              ffx_d   = vec_x;
              ffidx_d = vec_q;
            end
          end
          if (vec_d == num_q) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      num_q   <= '0;
      err_q   <= '0;
      vec_q   <= '0;
      fail_q  <= 1'b0;
      ffx_q   <= '0;
      ffidx_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      err_q   <= err_d;
      vec_q   <= vec_d;
      fail_q  <= fail_d;
      ffx_q   <= ffx_d;
      ffidx_q <= ffidx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = (state_q == DONE) && (err_q == '0);
  assign err_cnt        = err_q;
  assign vec_cnt        = vec_q;
  assign fail_seen      = fail_q;
  assign first_fail_x   = ffx_q;
  assign first_fail_idx = ffidx_q;

endmodule

// File: tb/tb_and_gate_checker.sv
// Directed self-checking bench for and_gate_checker.
module tb_and_gate_checker;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_vec;
  logic             vec_valid;
  logic [WIDTH-1:0] vec_x;
  logic             dut_y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] vec_cnt;
  logic             fail_seen;
  logic [WIDTH-1:0] first_fail_x;
  logic [CNT_W-1:0] first_fail_idx;

  int n_checks;
  int n_fails;

  and_gate_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .num_vec        (num_vec),
    .vec_valid      (vec_valid),
    .vec_x          (vec_x),
    .dut_y          (dut_y),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_cnt        (err_cnt),
    .vec_cnt        (vec_cnt),
    .fail_seen      (fail_seen),
    .first_fail_x   (first_fail_x),
    .first_fail_idx (first_fail_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input int n);
    @(negedge clk);
    start   = 1'b1;
    num_vec = CNT_W'(n);
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic apply_vec(input logic [WIDTH-1:0] x, input logic y);
    @(negedge clk);
    vec_valid = 1'b1;
    vec_x     = x;
    dut_y     = y;
    @(negedge clk);
    vec_valid = 1'b0;
    dut_y     = 1'b0;
  endtask

  logic [WIDTH-1:0] xs [6];
  logic             ys [6];

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    rst_n     = 1'b1;
    start     = 1'b0;
    num_vec   = '0;
    vec_valid = 1'b0;
    vec_x     = '0;
    dut_y     = 1'b0;
    xs = '{8'h00, 8'hFF, 8'hDF, 8'hBF, 8'hEF, 8'hFB};
    ys = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    #3 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_vec_cnt", 32'(vec_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean run of six vectors.
    start_run(6);
    check("t1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) apply_vec(xs[i], ys[i]);
    check("t1_done", 32'(done), 32'd1);
    check("t1_pass", 32'(pass), 32'd1);
    check("t1_err", 32'(err_cnt), 32'd0);
    check("t1_vec", 32'(vec_cnt), 32'd6);
    check("t1_fail_seen", 32'(fail_seen), 32'd0);
    check("t1_busy_off", 32'(busy), 32'd0);

    // Same sequence with wrong outputs at indices 2 and 5.
    start_run(6);
    for (int i = 0; i < 6; i++) apply_vec(xs[i], (i == 2 || i == 5) ? 1'b1 : ys[i]);
    check("t2_done", 32'(done), 32'd1);
    check("t2_pass", 32'(pass), 32'd0);
    check("t2_err", 32'(err_cnt), 32'd2);
    check("t2_ffx", 32'(first_fail_x), 32'hDF);
    check("t2_ffidx", 32'(first_fail_idx), 32'd2);
    check("t2_fail_seen", 32'(fail_seen), 32'd1);

    // Unknown output on the first vector (golden value 1 so it fails in any simulator).
    start_run(2);
    apply_vec(8'hFF, 1'bx);
    apply_vec(8'h00, 1'b0);
    check("t3_err", 32'(err_cnt), 32'd1);
    check("t3_ffidx", 32'(first_fail_idx), 32'd0);
    check("t3_ffx", 32'(first_fail_x), 32'hFF);
    check("t3_pass", 32'(pass), 32'd0);

    // Zero-length run, then vec_valid in DONE.
    start_run(0);
    check("t4_done", 32'(done), 32'd1);
    check("t4_pass", 32'(pass), 32'd1);
    check("t4_vec", 32'(vec_cnt), 32'd0);
    check("t4_err", 32'(err_cnt), 32'd0);
    apply_vec(8'hFF, 1'b0);
    check("t4_vec_hold", 32'(vec_cnt), 32'd0);
    check("t4_err_hold", 32'(err_cnt), 32'd0);
    check("t4_done_hold", 32'(done), 32'd1);

    // Start ignored mid-run; idle gaps hold state.
    start_run(4);
    apply_vec(8'h12, 1'b0);
    apply_vec(8'hFF, 1'b1);
    start_run(9);
    check("t5_busy", 32'(busy), 32'd1);
    check("t5_vec_mid", 32'(vec_cnt), 32'd2);
    repeat (3) @(negedge clk);
    check("t5_vec_gap", 32'(vec_cnt), 32'd2);
    apply_vec(8'h7F, 1'b0);
    check("t5_not_done", 32'(done), 32'd0);
    apply_vec(8'hFF, 1'b0);
    check("t5_done", 32'(done), 32'd1);
    check("t5_vec", 32'(vec_cnt), 32'd4);
    check("t5_err", 32'(err_cnt), 32'd1);
    check("t5_ffidx", 32'(first_fail_idx), 32'd3);

    // Asynchronous reset mid-run.
    start_run(5);
    apply_vec(8'h01, 1'b1);
    apply_vec(8'h00, 1'b0);
    apply_vec(8'hFF, 1'b1);
    check("t6_pre_vec", 32'(vec_cnt), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_vec", 32'(vec_cnt), 32'd0);
    check("t6_err", 32'(err_cnt), 32'd0);
    check("t6_fail_seen", 32'(fail_seen), 32'd0);
    check("t6_ffx", 32'(first_fail_x), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_run(1);
    apply_vec(8'hFF, 1'b1);
    check("t6b_done", 32'(done), 32'd1);
    check("t6b_pass", 32'(pass), 32'd1);
    check("t6b_vec", 32'(vec_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
